// File: rtl/fsm_core_pkg.sv
// Shared types for the fsm_core detector: the state type with its fixed
// two-bit binary encoding.
package fsm_core_pkg;

    typedef enum logic [1:0] {
        Q0 = 2'b00,
        Q1 = 2'b01,
        Q2 = 2'b10,
        Q3 = 2'b11
    } state_e;

    function automatic logic is_detect(input state_e s);
        return s == Q2;
    endfunction

endpackage

// File: rtl/fsm_core.sv
// Moore detector: j is high while two or more consecutive 1s have been sampled on i.
// A 1 seen in the release state starts a new run.
module fsm_core
    import fsm_core_pkg::*;
(
    input  logic clk,
    input  logic rst,
    input  logic i,
    output logic j
);

    state_e state_q, state_d;
    logic   j_q;

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q <= Q0;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = Q0;
        unique case (state_q)
            Q0:      state_d = i ? Q1 : Q0;
            Q1:      state_d = i ? Q2 : Q0;
            Q2:      state_d = i ? Q2 : Q3;
            Q3:      state_d = i ? Q1 : Q0;
            default: state_d = Q0;
        endcase
    end

    // Decoded from the next state so j moves on the same edge as state_q.
    always_ff @(posedge clk) begin
        if (!rst) begin
            j_q <= 1'b0;
        end else begin
            j_q <= is_detect(state_d);
        end
    end

    assign j = j_q;

endmodule

// File: tb/tb_fsm_core.sv
// Directed and random checks of fsm_core against a run-length model of the
// input stream.
module tb_fsm_core;

    logic clk;
    logic rst;
    logic i;
    logic j;

    int tests;
    int fails;
    int run_len;
    int prev_run;

    fsm_core dut (
        .clk (clk),
        .rst (rst),
        .i   (i),
        .j   (j)
    );

    initial clk = 1'b0;
    always #10 clk = ~clk;

    // Expected state from the length of the current run of 1s and of the run just ended.
    function automatic logic [1:0] model_state();
        if (run_len >= 2) return 2'd2;
        if (run_len == 1) return 2'd1;
        if (prev_run >= 2) return 2'd3;
        return 2'd0;
    endfunction

    task automatic step(input logic rst_v, input logic i_v, input int exp_j);
        logic [1:0] obs_state;
        logic       exp_jm;
        @(negedge clk);
        rst = rst_v;
        i   = i_v;
        @(posedge clk);
        if (!rst_v) begin
            run_len  = 0;
            prev_run = 0;
        end else if (i_v) begin
            prev_run = run_len;
            run_len  = (run_len < 100) ? run_len + 1 : run_len;
        end else begin
            prev_run = run_len;
            run_len  = 0;
        end
        #1;
        exp_jm    = (run_len >= 2);
        obs_state = dut.state_q;
        tests++;
        assert (j === exp_jm) else begin
            fails++;
            $error("FAIL j_model: observed %b expected %b (rst=%b i=%b)", j, exp_jm, rst_v, i_v);
        end
        tests++;
        assert (obs_state === model_state()) else begin
            fails++;
            $error("FAIL state_model: observed %b expected %b (rst=%b i=%b)",
                   obs_state, model_state(), rst_v, i_v);
        end
        if (exp_j >= 0) begin
            tests++;
            assert (j === exp_j[0]) else begin
                fails++;
                $error("FAIL j_directed: observed %b expected %b", j, exp_j[0]);
            end
        end
    endtask

    initial begin
        tests    = 0;
        fails    = 0;
        run_len  = 0;
        prev_run = 0;
        rst      = 1'b0;
        i        = 1'b0;

        // Reset with i=1
        step(1'b0, 1'b1, 0);

        // Basic detect
        step(1'b1, 1'b0, 0);
        step(1'b1, 1'b0, 0);
        step(1'b1, 1'b1, 0);
        step(1'b1, 1'b1, 1);
        step(1'b1, 1'b0, 0);
        step(1'b1, 1'b0, 0);

        // Long run
        step(1'b1, 1'b1, 0);
        for (int k = 0; k < 5; k++) step(1'b1, 1'b1, 1);
        step(1'b1, 1'b0, 0);

        // Reset mid-run from Q2
        step(1'b1, 1'b1, 0);
        step(1'b1, 1'b1, 1);
        step(1'b0, 1'b1, 0);
        step(1'b1, 1'b1, 0);

        // Isolated ones, starting from Q0
        step(1'b1, 1'b0, 0);
        step(1'b1, 1'b1, 0);
        step(1'b1, 1'b0, 0);
        step(1'b1, 1'b1, 0);
        step(1'b1, 1'b0, 0);

        // Re-arm through Q3
        step(1'b1, 1'b1, 0);
        step(1'b1, 1'b1, 1);
        step(1'b1, 1'b0, 0);
        step(1'b1, 1'b1, 0);
        step(1'b1, 1'b1, 1);

        // Random stream with occasional resets
        for (int k = 0; k < 400; k++) begin
            step(($urandom_range(0, 15) != 0), $urandom_range(0, 2) != 0, -1);
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
